// File: rtl/inst_queue_if.sv
// Fetch/dispatch-facing bundle of the instruction queue.
// With IQ_PREDECODE_EN defined the bundle also carries out_is_ctrl/out_is_mem.
interface inst_queue_if #(
    parameter int unsigned PTR_W = 3
);
    logic             push_valid;
    logic [31:0]      push_inst;
    logic [31:0]      push_npc;
    logic             iq_full;
    logic             deq_ready;
    logic             out_valid;
    logic [31:0]      out_inst;
    logic [31:0]      out_pc;
    logic [31:0]      out_npc;
    logic [PTR_W:0]   count;
`ifdef IQ_PREDECODE_EN
    logic             out_is_ctrl;
    logic             out_is_mem;
`endif

    // Producer/consumer side (fetch + dispatch)
    modport master (
        output push_valid, push_inst, push_npc, deq_ready,
        input  iq_full, out_valid, out_inst, out_pc, out_npc, count
`ifdef IQ_PREDECODE_EN
        , input out_is_ctrl, out_is_mem
`endif
    );

    // Queue side
    modport slave (
        input  push_valid, push_inst, push_npc, deq_ready,
        output iq_full, out_valid, out_inst, out_pc, out_npc, count
`ifdef IQ_PREDECODE_EN
        , output out_is_ctrl, out_is_mem
`endif
    );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode/dispatch: circular buffer of
// DEPTH entries {inst, pc, npc}, one-cycle flush on ROB redirect.
// Optional feature macro: IQ_PREDECODE_EN (stores is_ctrl/is_mem per entry).
module inst_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    inst_queue_if.slave      iq
);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] inst_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];
    logic [31:0] npc_q  [DEPTH];
`ifdef IQ_PREDECODE_EN
    logic        ctrl_q [DEPTH];
    logic        mem_q  [DEPTH];
    logic        push_ctrl_c;
    logic        push_mem_c;
    logic [6:0]  opcode_c;
`endif

    logic flush_c;
    logic push_fire_c;
    logic pop_fire_c;
    logic overflow_c;
    logic q_full_c;

    // Handshake qualification and pointer/count next state
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        flush_c     = rdy_in & flush;
        q_full_c    = (count_q == CNT_W'(DEPTH));
        pop_fire_c  = rdy_in & ~flush & (count_q != '0) & iq.deq_ready;
        push_fire_c = rdy_in & ~flush & iq.push_valid & (~q_full_c | pop_fire_c);
        overflow_c  = rdy_in & ~flush & iq.push_valid & q_full_c & ~pop_fire_c;

        if (flush_c) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_fire_c) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop_fire_c) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push_fire_c && !pop_fire_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_fire_c && !push_fire_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

`ifdef IQ_PREDECODE_EN
    // Predecode of the incoming opcode
    always_comb begin
        opcode_c    = iq.push_inst[6:0];
        push_ctrl_c = (opcode_c == 7'b1100011) || (opcode_c == 7'b1101111) ||
                      (opcode_c == 7'b1100111);
        push_mem_c  = (opcode_c == 7'b0000011) || (opcode_c == 7'b0100011);
    end
`endif

    // Pointer and occupancy registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; pc is derived once at push so the read path is a plain mux
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
                npc_q[i]  <= '0;
`ifdef IQ_PREDECODE_EN
                ctrl_q[i] <= 1'b0;
                mem_q[i]  <= 1'b0;
`endif
            end
        end else if (push_fire_c) begin
            inst_q[tail_q] <= iq.push_inst;
            pc_q[tail_q]   <= iq.push_npc - 32'd4;
            npc_q[tail_q]  <= iq.push_npc;
`ifdef IQ_PREDECODE_EN
            ctrl_q[tail_q] <= push_ctrl_c;
            mem_q[tail_q]  <= push_mem_c;
`endif
        end
    end

    // Head read and status flags
    always_comb begin
        iq.out_valid = (count_q != '0);
        iq.iq_full   = (count_q >= CNT_W'(DEPTH - 1));
        iq.count     = count_q;
        iq.out_inst  = inst_q[head_q];
        iq.out_pc    = pc_q[head_q];
        iq.out_npc   = npc_q[head_q];
`ifdef IQ_PREDECODE_EN
        iq.out_is_ctrl = ctrl_q[head_q];
        iq.out_is_mem  = mem_q[head_q];
`endif
    end

`ifndef SYNTHESIS
    // Report pushes that arrive while the queue is completely full
    always_ff @(posedge clk_in) begin
        if (rst_in && overflow_c) begin
            $info("iq overflow");
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed testbench for inst_queue (DEPTH=8).
module tb_inst_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = 3;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    logic flush  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    inst_queue_if #(.PTR_W(PTR_W)) bus ();

    inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush),
        .iq     (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] npc);
        bus.push_valid = 1'b1;
        bus.push_inst  = inst;
        bus.push_npc   = npc;
        tick();
        bus.push_valid = 1'b0;
    endtask

    initial begin
        bus.push_valid = 1'b0;
        bus.push_inst  = '0;
        bus.push_npc   = '0;
        bus.deq_ready  = 1'b0;

        // Reset state
        #12;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_full",  32'(bus.iq_full), 32'd0);
        check("rst_inst",  bus.out_inst, 32'd0);
        check("rst_pc",    bus.out_pc, 32'd0);
        rst_in = 1'b1;
        tick();

        // Three pushes, then three in-order pops
        push(32'h13, 32'h4);
        push(32'h13, 32'h8);
        push(32'h13, 32'hC);
        check("p3_count", 32'(bus.count), 32'd3);
        check("p3_pc",    bus.out_pc, 32'h0);
        check("p3_full",  32'(bus.iq_full), 32'd0);
        check("p3_npc",   bus.out_npc, 32'h4);
        bus.deq_ready = 1'b1;
        check("pop0_pc", bus.out_pc, 32'h0);
        tick();
        check("pop1_pc", bus.out_pc, 32'h4);
        tick();
        check("pop2_pc", bus.out_pc, 32'h8);
        tick();
        check("pop_empty", 32'(bus.out_valid), 32'd0);
        bus.deq_ready = 1'b0;

        // rdy_in low blocks a push
        rdy_in = 1'b0;
        bus.push_valid = 1'b1;
        bus.push_inst  = 32'hBAD;
        tick();
        bus.push_valid = 1'b0;
        rdy_in = 1'b1;
        check("rdy_hold", 32'(bus.count), 32'd0);

        // Fill to DEPTH, then an overflowing push
        for (int i = 0; i < 6; i++) push(32'(i), 32'h100 + 32'(4 * i));
        check("fill6_full", 32'(bus.iq_full), 32'd0);
        push(32'd6, 32'h118);
        check("fill7_count", 32'(bus.count), 32'd7);
        check("fill7_full",  32'(bus.iq_full), 32'd1);
        push(32'd7, 32'h11C);
        check("fill8_count", 32'(bus.count), 32'd8);
        push(32'd9, 32'h200);
        check("ovf_count", 32'(bus.count), 32'd8);
        check("ovf_head",  bus.out_pc, 32'hFC);

        // Push and pop together at full
        bus.deq_ready  = 1'b1;
        push(32'hAA, 32'h500);
        check("full_pp_count", 32'(bus.count), 32'd8);
        for (int k = 1; k <= 7; k++) begin
            check("full_drain_pc", bus.out_pc, 32'h100 + 32'(4 * (k - 1)));
            tick();
        end
        check("late_inst",  bus.out_inst, 32'hAA);
        check("late_pc",    bus.out_pc, 32'h4FC);
        check("late_count", 32'(bus.count), 32'd1);
        tick();
        check("late_empty", 32'(bus.out_valid), 32'd0);
        bus.deq_ready = 1'b0;

        // Streaming push+pop across pointer wrap
        push(32'h1000, 32'h2000);
        bus.deq_ready = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            bus.push_valid = 1'b1;
            bus.push_inst  = 32'h1000 + 32'(j);
            bus.push_npc   = 32'h2000 + 32'(4 * j);
            check("stream_inst", bus.out_inst, 32'h1000 + 32'(j - 1));
            tick();
            check("stream_count", 32'(bus.count), 32'd1);
        end
        bus.push_valid = 1'b0;
        check("stream_last", bus.out_inst, 32'h1014);
        tick();
        bus.deq_ready = 1'b0;
        check("stream_empty", 32'(bus.out_valid), 32'd0);

        // Flush beats a simultaneous push and pop
        for (int i = 0; i < 5; i++) push(32'h3000 + 32'(i), 32'h4000 + 32'(4 * i));
        check("pre_flush_count", 32'(bus.count), 32'd5);
        flush          = 1'b1;
        bus.deq_ready  = 1'b1;
        push(32'hDEAD, 32'h9000);
        flush          = 1'b0;
        bus.deq_ready  = 1'b0;
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_full",  32'(bus.iq_full), 32'd0);
        push(32'h77, 32'h8);
        check("post_flush_inst",  bus.out_inst, 32'h77);
        check("post_flush_count", 32'(bus.count), 32'd1);
        bus.deq_ready = 1'b1;
        tick();
        bus.deq_ready = 1'b0;

        // Asynchronous reset between clock edges
        for (int i = 0; i < 4; i++) push(32'h5000 + 32'(i), 32'h6004 + 32'(4 * i));
        check("pre_rst_count", 32'(bus.count), 32'd4);
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_inst",  bus.out_inst, 32'd0);
        #2;
        rst_in = 1'b1;
        tick();

`ifdef IQ_PREDECODE_EN
        // Predecode bits follow the head entry
        push(32'h0000006F, 32'h4);
        check("pd_jal_ctrl", 32'(bus.out_is_ctrl), 32'd1);
        check("pd_jal_mem",  32'(bus.out_is_mem), 32'd0);
        push(32'h00002003, 32'h8);
        bus.deq_ready = 1'b1;
        tick();
        bus.deq_ready = 1'b0;
        check("pd_ld_ctrl", 32'(bus.out_is_ctrl), 32'd0);
        check("pd_ld_mem",  32'(bus.out_is_mem), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and decode/dispatch. It buffers up to `DEPTH` fetched instructions, together with their addresses. This decouples fetch's one-instruction-per-cycle delivery from dispatch stalls caused by ROB, RS or LSB back-pressure. On a ROB redirect (`change_pc`) it discards all buffered work in one cycle.

## Interface
Parameters:
- `DEPTH`, default 8: number of entries; must be a power of two and at least 4.
- `PTR_W`, default 3: equals log2(`DEPTH`).

Ports:
- `clk_in`  input  1  clock; all state updates on the rising edge.
- `rst_in`  input  1  asynchronous, active-low reset.
- `rdy_in`  input  1  global enable; when low, all state holds and no push or pop is accepted.
- `flush`  input  1  ROB `change_pc`; clears the queue.
- `push_valid`  input  1  fetch `fetch_rdy`.
- `push_inst`  input  32  fetched instruction word.
- `push_npc`  input  32  address of the following instruction (instruction address + 4).
- `iq_full`  output  1  back-pressure to fetch; replaces fetch's RS/ROB/LSB full term.
- `deq_ready`  input  1  decode/dispatch can take the head entry this cycle.
- `out_valid`  output  1  head entry is present.
- `out_inst`  output  32  head instruction.
- `out_pc`  output  32  head instruction address (`push_npc` − 4).
- `out_npc`  output  32  head `push_npc`.
- `count`  output  `PTR_W`+1  number of occupied entries.

## Operation
- Storage is a circular buffer with `head`/`tail` pointers of `PTR_W` bits, plus a `count` register. Pointers wrap modulo `DEPTH`.
- Push fires when `rdy_in` and `push_valid` and no `flush`, and either `count` < `DEPTH` or a pop fires in the same cycle.
  - On push, the entry at `tail` is written with `{push_inst, push_npc}`, `out_pc` is derived as `push_npc` − 4 (32-bit wrap), and `tail` increments.
- Pop fires when `rdy_in` and `out_valid` and `deq_ready` and no `flush`. On pop, `head` increments.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop fire together, including at full and at empty±1.
- `out_valid` is `count` ≠ 0. The `out_*` fields are a combinational read of the entry at `head`.
- `iq_full` is `count` ≥ `DEPTH` − 1, derived combinationally from registered `count`.
  - The one-entry margin absorbs the instruction fetch already issued in the cycle before it samples `iq_full`. Fetch's outputs are registered, so one push can land after `iq_full` rises.
- Push when `count` == `DEPTH` with no pop is a protocol error: the entry is dropped, state is unchanged, and simulation prints `"iq overflow"`.
- Flush, when `rdy_in` is high:
  - `head`, `tail` and `count` become 0.
  - A push or pop in the same cycle is discarded.
  - Flush has priority over everything except reset.
- Reset (`rst_in` low, asynchronous):
  - `head`, `tail` and `count` become 0, so `out_valid`=0 and `iq_full`=0.
  - `out_inst`/`out_pc`/`out_npc` read entry 0, which is cleared to 0.
  - Reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Entry data registers other than entry 0 need not be cleared.

## Timing
- Push-to-visible latency is 1 cycle: an entry pushed at edge N appears at the head no earlier than after edge N, and `out_valid` is high in cycle N+1 if the queue was empty.
- There is no same-cycle bypass from `push_*` to `out_*`.
- Sustained throughput is one push and one pop per cycle.
- `flush` asserted in cycle N: `out_valid`=0 and `iq_full`=0 from cycle N+1. The first post-flush push is accepted in cycle N+1.
- `rdy_in` low freezes pointers and `count`; outputs stay stable.

## Configuration
- `IQ_PREDECODE_EN` defined: each entry also stores two predecode bits, computed at push from `push_inst[6:0]`:
  - `is_ctrl` = opcode ∈ {1100011, 1101111, 1100111}.
  - `is_mem` = opcode ∈ {0000011, 0100011}.
  - They are exported as ports `out_is_ctrl` and `out_is_mem` (1 bit each, reset 0) with the same timing as `out_inst`.
- `IQ_PREDECODE_EN` undefined: those ports and bits do not exist; all other behaviour is identical.

## Test plan
- Reset, then 3 pushes (inst 0x00000013, npc 0x4/0x8/0xC) with `deq_ready`=0:
  - `count`=3, `out_pc`=0x0, `iq_full`=0.
  - Then `deq_ready`=1 pops 3 in order with `out_pc` 0x0, 0x4, 0x8; `out_valid`=0 afterwards.
- Fill with `DEPTH`=8 and `deq_ready`=0:
  - `iq_full` rises when `count`=7.
  - A final in-flight push reaches `count`=8.
  - A 9th push is dropped and `"iq overflow"` is printed.
- At `count`=8, push and pop in the same cycle: `count` stays 8, the head advances, and the new entry appears 8 pops later.
- Continuous push+pop for 20 cycles across pointer wrap: `count` constant at 1, and the output sequence matches the input with no loss.
- `count`=5, then `flush`+`push_valid`+`deq_ready` in the same cycle: next cycle `count`=0, `out_valid`=0, and the pushed entry is absent.
- `rst_in` pulsed low between clock edges with `count`=4: `out_valid` drops immediately and `count`=0.
  - With `IQ_PREDECODE_EN`, pushing 0x0000006F gives `out_is_ctrl`=1 and `out_is_mem`=0.
